// File: rtl/stream_aligner_pkg.sv
// Shared definitions for the stream aligner.
//   - state_e    : aligner FSM states (SCALE, STREAM, FLUSH)
//   - DATA_LSB   : bit offset of the data field inside the joined tuple
//   - grid_lsb() : bit offset of the grid field for a given data width
//   - scale_lsb(): bit offset of the scale field for a given data width
// Tuple layout, MSB to LSB: {scale, grid, data}.
package stream_aligner_pkg;

  typedef enum logic [1:0] {
    ST_SCALE  = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

  localparam int DATA_LSB = 0;

  function automatic int grid_lsb(input int data_width);
    return data_width;
  endfunction

  function automatic int scale_lsb(input int data_width);
    return 2 * data_width;
  endfunction

endpackage

// File: rtl/stream_aligner_outreg.sv
// Single-entry output register for the aligner's master stream.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   load                : capture load_data/load_last this cycle
//   load_data/load_last : tuple and tlast to capture
//   m_tready            : downstream ready
//   m_tvalid/m_tdata/m_tlast : registered master stream outputs
//   slot_free           : register may accept a load this cycle
module stream_aligner_outreg #(
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             m_tready,
  output logic             m_tvalid,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tlast,
  output logic             slot_free
);

  logic             tvalid_q, tvalid_d;
  logic [WIDTH-1:0] tdata_q, tdata_d;
  logic             tlast_q, tlast_d;

  // The slot frees up in the same cycle the current beat is taken, which is
  // what lets the aligner sustain one beat per cycle.
  always_comb begin
    slot_free = !tvalid_q || m_tready;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    tlast_d   = tlast_q;
    if (load) begin
      tvalid_d = 1'b1;
      tdata_d  = load_data;
      tlast_d  = load_last;
    end else if (tvalid_q && m_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
    end else begin
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
    end
  end

  assign m_tvalid = tvalid_q;
  assign m_tdata  = tdata_q;
  assign m_tlast  = tlast_q;

endmodule

// File: rtl/stream_aligner.sv
// Joins a data stream and a grid stream beat-for-beat, tagging every joined
// beat with the scale word received at the start of the packet.
// Ports:
//   clk, rst_n                     : clock, synchronous active-low reset
//   s_axis_data_*                  : data stream (tdata/tvalid/tready/tlast)
//   s_axis_grid_*                  : grid stream (tdata/tvalid/tready/tlast)
//   s_axis_scle_*                  : scale stream, one word per packet
//   m_axis_*                       : joined {scale, grid, data} stream
//   beat_count                     : beats emitted so far in current packet
//   align_error                    : sticky flag, data/grid tlast disagreed
//   clear_error                    : clears align_error
// Build option: define STREAM_ALIGNER_FLUSH_EN to drain the remainder of the
// longer stream after a tlast mismatch; otherwise the aligner returns
// straight to waiting for the next scale word.
module stream_aligner
  import stream_aligner_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int SCALE_WIDTH = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_WIDTH-1:0]             s_axis_data_tdata,
  input  logic                              s_axis_data_tvalid,
  output logic                              s_axis_data_tready,
  input  logic                              s_axis_data_tlast,
  input  logic [DATA_WIDTH-1:0]             s_axis_grid_tdata,
  input  logic                              s_axis_grid_tvalid,
  output logic                              s_axis_grid_tready,
  input  logic                              s_axis_grid_tlast,
  input  logic [SCALE_WIDTH-1:0]            s_axis_scle_tdata,
  input  logic                              s_axis_scle_tvalid,
  output logic                              s_axis_scle_tready,
  output logic [2*DATA_WIDTH+SCALE_WIDTH-1:0] m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [CNT_WIDTH-1:0]              beat_count,
  output logic                              align_error,
  input  logic                              clear_error
);

  localparam int TUPLE_W   = 2 * DATA_WIDTH + SCALE_WIDTH;
  localparam int GRID_LSB  = grid_lsb(DATA_WIDTH);
  localparam int SCALE_LSB = scale_lsb(DATA_WIDTH);

  state_e                 state_q, state_d;
  logic [SCALE_WIDTH-1:0] scale_q, scale_d;
  logic [CNT_WIDTH-1:0]   beat_count_q, beat_count_d;
  logic                   align_error_q, align_error_d;
  // Which stream is being drained in FLUSH: 1 = grid, 0 = data.
  logic                   flush_grid_q, flush_grid_d;

  logic               slot_free;
  logic               join_beat;
  logic               mismatch;
  logic               both_last;
  logic               join_last;
  logic [TUPLE_W-1:0] join_tuple;
  logic               m_hs;

  // State register together with the per-packet bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_SCALE;
      scale_q       <= '0;
      beat_count_q  <= '0;
      align_error_q <= 1'b0;
      flush_grid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      scale_q       <= scale_d;
      beat_count_q  <= beat_count_d;
      align_error_q <= align_error_d;
      flush_grid_q  <= flush_grid_d;
    end
  end

  // Handshake outputs. Every tready is held low while rst_n is asserted so
  // nothing is consumed in the reset cycle. Data and grid are only ever
  // accepted together while streaming.
  always_comb begin
    s_axis_scle_tready = 1'b0;
    s_axis_data_tready = 1'b0;
    s_axis_grid_tready = 1'b0;
    join_beat          = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_SCALE: s_axis_scle_tready = 1'b1;
        ST_STREAM: begin
          join_beat          = s_axis_data_tvalid && s_axis_grid_tvalid && slot_free;
          s_axis_data_tready = join_beat;
          s_axis_grid_tready = join_beat;
        end
        ST_FLUSH: begin
          if (flush_grid_q) s_axis_grid_tready = 1'b1;
          else              s_axis_data_tready = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Joined tuple and its tlast. A mismatching beat always closes the packet
  // on the output side.
  always_comb begin
    join_tuple = '0;
    join_tuple[DATA_LSB  +: DATA_WIDTH]  = s_axis_data_tdata;
    join_tuple[GRID_LSB  +: DATA_WIDTH]  = s_axis_grid_tdata;
    join_tuple[SCALE_LSB +: SCALE_WIDTH] = scale_q;
    mismatch  = join_beat && (s_axis_data_tlast != s_axis_grid_tlast);
    both_last = join_beat && s_axis_data_tlast && s_axis_grid_tlast;
`ifdef STREAM_ALIGNER_FLUSH_EN
    join_last = mismatch ? 1'b1 : s_axis_data_tlast;
`else
    join_last = s_axis_data_tlast | s_axis_grid_tlast;
`endif
  end

  // Next-state and bookkeeping logic.
  always_comb begin
    state_d      = state_q;
    scale_d      = scale_q;
    flush_grid_d = flush_grid_q;
    case (state_q)
      ST_SCALE: begin
        if (s_axis_scle_tvalid && s_axis_scle_tready) begin
          scale_d = s_axis_scle_tdata;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (both_last) begin
          state_d = ST_SCALE;
        end else if (mismatch) begin
`ifdef STREAM_ALIGNER_FLUSH_EN
          // The stream that already ended is complete; drain the other one.
          state_d      = ST_FLUSH;
          flush_grid_d = s_axis_data_tlast;
`else
          state_d = ST_SCALE;
`endif
        end
      end
      ST_FLUSH: begin
        if (flush_grid_q ? (s_axis_grid_tvalid && s_axis_grid_tlast)
                         : (s_axis_data_tvalid && s_axis_data_tlast)) begin
          state_d = ST_SCALE;
        end
      end
      default: state_d = ST_SCALE;
    endcase

    m_hs = m_axis_tvalid && m_axis_tready;
    beat_count_d = beat_count_q;
    if (m_hs) beat_count_d = m_axis_tlast ? '0 : beat_count_q + CNT_WIDTH'(1);

    // A new mismatch takes priority over a clear in the same cycle.
    if (mismatch)         align_error_d = 1'b1;
    else if (clear_error) align_error_d = 1'b0;
    else                  align_error_d = align_error_q;
  end

  stream_aligner_outreg #(
    .WIDTH(TUPLE_W)
  ) u_outreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (join_beat),
    .load_data(join_tuple),
    .load_last(join_last),
    .m_tready (m_axis_tready),
    .m_tvalid (m_axis_tvalid),
    .m_tdata  (m_axis_tdata),
    .m_tlast  (m_axis_tlast),
    .slot_free(slot_free)
  );

  assign beat_count  = beat_count_q;
  assign align_error = align_error_q;

endmodule

// File: tb/tb_stream_aligner.sv
// Self-checking bench for stream_aligner. Packets are described as
// (scale, data length, grid length); the expected output beats are derived
// from that description and compared beat by beat against the master stream.
// Honors STREAM_ALIGNER_FLUSH_EN the same way the design does.
module tb_stream_aligner;

  localparam int DW = 16;
  localparam int SW = 16;
  localparam int CW = 16;
  localparam int TW = 2 * DW + SW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_axis_data_tdata = '0;
  logic          s_axis_data_tvalid = 1'b0;
  logic          s_axis_data_tready;
  logic          s_axis_data_tlast = 1'b0;
  logic [DW-1:0] s_axis_grid_tdata = '0;
  logic          s_axis_grid_tvalid = 1'b0;
  logic          s_axis_grid_tready;
  logic          s_axis_grid_tlast = 1'b0;
  logic [SW-1:0] s_axis_scle_tdata = '0;
  logic          s_axis_scle_tvalid = 1'b0;
  logic          s_axis_scle_tready;
  logic [TW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic [CW-1:0] beat_count;
  logic          align_error;
  logic          clear_error = 1'b0;

  stream_aligner #(
    .DATA_WIDTH (DW),
    .SCALE_WIDTH(SW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .s_axis_data_tdata (s_axis_data_tdata),
    .s_axis_data_tvalid(s_axis_data_tvalid),
    .s_axis_data_tready(s_axis_data_tready),
    .s_axis_data_tlast (s_axis_data_tlast),
    .s_axis_grid_tdata (s_axis_grid_tdata),
    .s_axis_grid_tvalid(s_axis_grid_tvalid),
    .s_axis_grid_tready(s_axis_grid_tready),
    .s_axis_grid_tlast (s_axis_grid_tlast),
    .s_axis_scle_tdata (s_axis_scle_tdata),
    .s_axis_scle_tvalid(s_axis_scle_tvalid),
    .s_axis_scle_tready(s_axis_scle_tready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast),
    .beat_count        (beat_count),
    .align_error       (align_error),
    .clear_error       (clear_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [TW-1:0] tuple;
    logic          last;
  } exp_t;

  beat_t         dq[$];
  beat_t         gq[$];
  logic [SW-1:0] sq[$];
  exp_t          eq[$];

  int      vectors = 0;
  int      miscompares = 0;
  logic [CW-1:0] exp_beat = '0;
  int      tready_mode = 0;
  bit      gaps = 1'b0;
  bit      clear_on_mm = 1'b0;
  bit      tog = 1'b0;

`ifdef STREAM_ALIGNER_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  // One comparison: counts it, and reports observed/expected on a miss.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue a packet on the sources and its expected output beats. Only the
  // paired beats are emitted; the longer stream's extra beats are queued
  // only when they will be flushed by the design.
  task automatic pushPacket(input logic [SW-1:0] scale, input int nd, input int ng,
                            input bit rnd, input logic [DW-1:0] base_d, input logic [DW-1:0] base_g);
    logic [DW-1:0] dv[8];
    logic [DW-1:0] gv[8];
    int n_out;
    beat_t b;
    exp_t e;
    n_out = (nd < ng) ? nd : ng;
    for (int i = 0; i < 8; i++) begin
      dv[i] = rnd ? DW'($urandom) : base_d + DW'(i);
      gv[i] = rnd ? DW'($urandom) : base_g + DW'(i);
    end
    sq.push_back(scale);
    for (int i = 0; i < (FLUSH ? nd : n_out); i++) begin
      b.d = dv[i]; b.last = (i == nd - 1); dq.push_back(b);
    end
    for (int i = 0; i < (FLUSH ? ng : n_out); i++) begin
      b.d = gv[i]; b.last = (i == ng - 1); gq.push_back(b);
    end
    for (int i = 0; i < n_out; i++) begin
      e.tuple = {scale, gv[i], dv[i]};
      e.last  = (i == n_out - 1);
      eq.push_back(e);
    end
  endtask

  // Present the heads of the source queues and the sink's ready pattern.
  task automatic driveInputs();
    s_axis_data_tvalid = (dq.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
    s_axis_grid_tvalid = (gq.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
    s_axis_scle_tvalid = (sq.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
    s_axis_data_tdata  = (dq.size() > 0) ? dq[0].d : '0;
    s_axis_data_tlast  = (dq.size() > 0) ? dq[0].last : 1'b0;
    s_axis_grid_tdata  = (gq.size() > 0) ? gq[0].d : '0;
    s_axis_grid_tlast  = (gq.size() > 0) ? gq[0].last : 1'b0;
    s_axis_scle_tdata  = (sq.size() > 0) ? sq[0] : '0;
    case (tready_mode)
      0: m_axis_tready = 1'b1;
      1: begin tog = ~tog; m_axis_tready = tog; end
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
    clear_error = clear_on_mm && dq.size() > 0 && gq.size() > 0 && (dq[0].last != gq[0].last);
  endtask

  // One clock cycle: sample at the falling edge, retire handshakes after
  // the rising edge, then present the next inputs.
  task automatic applyStimulus();
    bit pd, pg, ps, pm;
    @(negedge clk);
    pd = s_axis_data_tvalid && s_axis_data_tready;
    pg = s_axis_grid_tvalid && s_axis_grid_tready;
    ps = s_axis_scle_tvalid && s_axis_scle_tready;
    pm = m_axis_tvalid && m_axis_tready;
    if (m_axis_tvalid) begin
      checkOutput("beat_expected", 64'(eq.size() > 0), 64'd1);
      if (eq.size() > 0) begin
        checkOutput("tdata", 64'(m_axis_tdata), 64'(eq[0].tuple));
        checkOutput("tlast", 64'(m_axis_tlast), 64'(eq[0].last));
      end
    end
    checkOutput("beat_count", 64'(beat_count), 64'(exp_beat));
    @(posedge clk);
    #1;
    if (pd && dq.size() > 0) void'(dq.pop_front());
    if (pg && gq.size() > 0) void'(gq.pop_front());
    if (ps && sq.size() > 0) void'(sq.pop_front());
    if (pm && eq.size() > 0) begin
      exp_beat = eq[0].last ? '0 : exp_beat + CW'(1);
      void'(eq.pop_front());
    end
    driveInputs();
  endtask

  task automatic runUntilIdle(input int budget);
    int n = 0;
    driveInputs();
    while ((dq.size() + gq.size() + sq.size() + eq.size()) > 0 && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("drained", 64'(dq.size() + gq.size() + sq.size() + eq.size()), 64'd0);
    repeat (3) applyStimulus();
  endtask

  initial begin
    $display("[TB] stream_aligner bench, flush variant = %0d", FLUSH);

    // Reset state.
    @(negedge clk);
    checkOutput("rst_scle_tready", 64'(s_axis_scle_tready), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("rst_tdata", 64'(m_axis_tdata), 64'd0);
    checkOutput("rst_beat_count", 64'(beat_count), 64'd0);
    checkOutput("rst_align_error", 64'(align_error), 64'd0);
    rst_n = 1'b1;

    // Basic packet with the sink always ready.
    $display("[TB] basic packet");
    pushPacket(16'h0003, 4, 4, 1'b0, 16'h0010, 16'h0020);
    runUntilIdle(50);

    // Same packet with the sink ready every other cycle.
    $display("[TB] backpressure");
    tready_mode = 1;
    pushPacket(16'h0003, 4, 4, 1'b0, 16'h0010, 16'h0020);
    runUntilIdle(50);
    tready_mode = 0;

    // Grid stream starved while data is available.
    $display("[TB] grid starved");
    pushPacket(16'h0005, 1, 1, 1'b0, 16'h0044, 16'h0055);
    begin
      beat_t held;
      held = gq.pop_front();
      driveInputs();
      applyStimulus();
      for (int i = 0; i < 5; i++) begin
        applyStimulus();
        checkOutput("starved_data_tready", 64'(s_axis_data_tready), 64'd0);
        checkOutput("starved_tvalid", 64'(m_axis_tvalid), 64'd0);
      end
      gq.push_back(held);
    end
    runUntilIdle(50);

    // Mismatch with clear_error asserted during the mismatching join.
    $display("[TB] mismatch with simultaneous clear");
    clear_on_mm = 1'b1;
    pushPacket(16'h0007, 2, 4, 1'b0, 16'h0010, 16'h0020);
    runUntilIdle(50);
    clear_on_mm = 1'b0;
    driveInputs();
    checkOutput("mismatch_beats_clear", 64'(align_error), 64'd1);

    // Reset after two beats of a packet.
    $display("[TB] mid-packet reset");
    pushPacket(16'h0009, 4, 4, 1'b1, 16'h0, 16'h0);
    driveInputs();
    begin
      int n = 0;
      while (eq.size() > 2 && n < 30) begin applyStimulus(); n++; end
    end
    checkOutput("pre_reset_progress", 64'(eq.size()), 64'd2);
    rst_n = 1'b0;
    dq.delete(); gq.delete(); sq.delete(); eq.delete();
    exp_beat = '0;
    s_axis_data_tvalid = 1'b1;
    s_axis_grid_tvalid = 1'b1;
    s_axis_scle_tvalid = 1'b1;
    @(negedge clk);
    checkOutput("rstcyc_data_tready", 64'(s_axis_data_tready), 64'd0);
    checkOutput("rstcyc_grid_tready", 64'(s_axis_grid_tready), 64'd0);
    checkOutput("rstcyc_scle_tready", 64'(s_axis_scle_tready), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("midrst_tlast", 64'(m_axis_tlast), 64'd0);
    checkOutput("midrst_tdata", 64'(m_axis_tdata), 64'd0);
    checkOutput("midrst_beat_count", 64'(beat_count), 64'd0);
    checkOutput("midrst_align_error", 64'(align_error), 64'd0);
    rst_n = 1'b1;
    pushPacket(16'h000A, 3, 3, 1'b1, 16'h0, 16'h0);
    runUntilIdle(50);

    // Plain mismatches in both directions, each cleared afterwards.
    $display("[TB] mismatch recovery");
    pushPacket(16'h000B, 2, 4, 1'b0, 16'h0010, 16'h0020);
    runUntilIdle(50);
    checkOutput("mismatch_grid_long", 64'(align_error), 64'd1);
    clear_error = 1'b1;
    @(posedge clk);
    #1;
    clear_error = 1'b0;
    checkOutput("error_cleared", 64'(align_error), 64'd0);
    pushPacket(16'h000C, 3, 1, 1'b0, 16'h0030, 16'h0040);
    runUntilIdle(50);
    checkOutput("mismatch_data_long", 64'(align_error), 64'd1);
    clear_error = 1'b1;
    @(posedge clk);
    #1;
    clear_error = 1'b0;
    checkOutput("error_cleared2", 64'(align_error), 64'd0);

    // Randomised packets with source gaps and random sink readiness.
    $display("[TB] random packets");
    gaps = 1'b1;
    tready_mode = 2;
    for (int p = 0; p < 20; p++) begin
      int nd, ng;
      nd = $urandom_range(1, 6);
      ng = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : nd;
      pushPacket(SW'($urandom), nd, ng, 1'b1, 16'h0, 16'h0);
    end
    runUntilIdle(3000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_aligner.md
STREAM_ALIGNER -- requirements
Module: stream_aligner

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of data and grid beats.
REQ-002 Parameter SCALE_WIDTH, default 16, width of scale word.
REQ-003 Parameter CNT_WIDTH, default 16, width of beat counter.
REQ-004 Port clk  in  1  single clock for all logic.
REQ-005 Port rst_n  in  1  synchronous, active-low reset.
REQ-006 Ports s_axis_data_tdata/tvalid/tready/tlast  in/in/out/in  DATA_WIDTH/1/1/1  data stream from memory control unit.
REQ-007 Ports s_axis_grid_tdata/tvalid/tready/tlast  in/in/out/in  DATA_WIDTH/1/1/1  grid stream from memory control unit.
REQ-008 Ports s_axis_scle_tdata/tvalid/tready  in/in/out  SCALE_WIDTH/1/1  scale stream, one word per packet.
REQ-009 Ports m_axis_tdata/tvalid/tready/tlast  out/out/in/out  2*DATA_WIDTH+SCALE_WIDTH/1/1/1  joined tuple {scale,grid,data}, data in LSBs.
REQ-010 Port beat_count  out  CNT_WIDTH  beats emitted in current packet.
REQ-011 Port align_error  out  1  sticky tlast-mismatch flag.
REQ-012 Port clear_error  in  1  clears align_error.

Function
REQ-013 FSM states SCALE, STREAM, FLUSH; SCALE entered from reset.
REQ-014 SCALE: s_axis_scle_tready=1, data/grid tready=0; on scale handshake latch word into scale_reg, go STREAM next cycle.
REQ-015 STREAM: slot_free = !m_axis_tvalid || m_axis_tready; join = data_tvalid && grid_tvalid && slot_free; data and grid tready both equal join (never one without the other).
REQ-016 On join, output register loads {scale_reg, grid_tdata, data_tdata}, m_axis_tvalid=1 next cycle (latency 1); tlast = data_tlast.
REQ-017 Output register holds tdata/tlast stable while tvalid && !tready; tvalid drops after handshake unless a new join occurs same cycle (full throughput, one beat/cycle).
REQ-018 Join with data_tlast=grid_tlast=1 returns FSM to SCALE.
REQ-019 Join with data_tlast != grid_tlast sets align_error; handling per REQ-027/028.
REQ-020 beat_count increments on each m_axis handshake, returns to 0 on handshake of a tlast beat; wraps modulo 2^CNT_WIDTH.
REQ-021 clear_error clears align_error; a simultaneous new mismatch wins (flag stays 1).
REQ-022 Scale tvalid arriving in STREAM/FLUSH is not accepted (tready=0).

Reset
REQ-023 rst_n=0 at clk edge: FSM to SCALE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, beat_count=0, align_error=0, scale_reg=0, all s_axis tready=0 in reset cycle.
REQ-024 Reset mid-packet discards the output register contents and any partially consumed packet; no beat is emitted after reset until a new scale word is accepted.

Configuration
REQ-025 Macro STREAM_ALIGNER_FLUSH_EN selects mismatch recovery.
REQ-026 Both variants share REQ-019 flag behaviour.
REQ-027 Defined: mismatching beat is emitted with tlast=1; FSM enters FLUSH, accepting and dropping beats of the stream that has not yet shown tlast (other stream tready=0) until its tlast handshake, then SCALE.
REQ-028 Undefined: mismatching beat emitted with tlast = data_tlast | grid_tlast; FSM goes directly to SCALE, no flush.

Structure
REQ-029 Shared package holds FSM state enumeration and tuple field offset constants.
REQ-030 One sub-module natural: stream_aligner_outreg (output register with slot_free logic).

Verification
REQ-031 Scale 0x0003, then 4 data/grid beats 0x10..0x13/0x20..0x23, tlast on 4th, tready=1 -> 4 output beats {0003,002n,001n}, tlast on 4th only, beat_count 0,1,2,3 then 0.
REQ-032 Same packet with m_axis_tready toggling 1/0 each cycle -> no beat lost or duplicated, tdata stable while stalled.
REQ-033 Grid tvalid held low 5 cycles while data valid -> data_tready stays 0, no output beat.
REQ-034 data_tlast on beat 2, grid_tlast on beat 4 -> align_error=1; with FLUSH_EN 2 beats output, grid beats 3-4 dropped, next scale accepted; without, 2 beats output, then SCALE.
REQ-035 rst_n=0 for 1 cycle after beat 2 of a packet -> outputs per REQ-023; new packet emits from beat_count 0 with new scale.
REQ-036 clear_error=1 same cycle as mismatch join -> align_error remains 1.
